// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
`timescale 1ns/1ps
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DEF_CLK_HZ = 12000000;
  localparam int unsigned DEF_BAUD   = 9600;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StWaitIdle
  } state_e;

  // 2-of-3 vote used for every bit decision.
  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable via clr.
`timescale 1ns/1ps
module uart_baud_tick #(
  parameter int unsigned DIV = 78
) (
  input  logic clk_12mhz,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk_12mhz) begin
    if (rst || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == W'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and ready/valid output.
// Define UART_RX_PARITY_EN to receive 8E1 (even parity checked, mismatch = framing error).
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEF_CLK_HZ,
  parameter int unsigned BAUD   = DEF_BAUD
) (
  input  logic       clk_12mhz,
  input  logic       rst,
  input  logic       uart_rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam int unsigned DIV = CLK_HZ / (BAUD * OVERSAMPLE);

  state_e     state;
  logic       sync1, sync2;
  logic [3:0] tcnt;
  logic [2:0] bcnt;
  logic [7:0] shreg;
  logic       s7, s8;
  logic       tick;
  logic       clr;
  logic       mid, last, bit_dec;

  // Restart the tick phase on the start edge so samples land mid-bit.
  assign clr     = (state == StIdle) && !sync2;
  assign mid     = tick && (tcnt == 4'd9);
  assign last    = tick && (tcnt == 4'd15);
  assign bit_dec = majority(s7, s8, sync2);

  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk_12mhz(clk_12mhz),
    .rst      (rst),
    .clr      (clr),
    .tick     (tick)
  );

  always_ff @(posedge clk_12mhz) begin
    if (rst) begin
      state       <= StIdle;
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      tcnt        <= '0;
      bcnt        <= '0;
      shreg       <= '0;
      s7          <= 1'b1;
      s8          <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      sync1       <= uart_rx_pin;
      sync2       <= sync1;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;

      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (tick) tcnt <= tcnt + 4'd1;
      if (tick && (tcnt == 4'd7)) s7 <= sync2;
      if (tick && (tcnt == 4'd8)) s8 <= sync2;

      unique case (state)
        StIdle: begin
          tcnt <= '0;
          if (!sync2) state <= StStart;
        end
        StStart: begin
          if (mid && bit_dec) state <= StIdle;
          else if (last) state <= StData;
        end
        StData: begin
          if (mid) shreg <= {bit_dec, shreg[7:1]};
          if (last) begin
            bcnt <= bcnt + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bcnt == 3'd7) state <= StParity;
`else
            if (bcnt == 3'd7) state <= StStop;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (mid && (bit_dec != ^shreg)) begin
            frame_err <= 1'b1;
            state     <= StWaitIdle;
          end else if (last) begin
            state <= StStop;
          end
        end
`endif
        StStop: begin
          if (mid) begin
            if (bit_dec) begin
              state <= StIdle;
              // A pending unaccepted byte wins; the new one is dropped.
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun_err <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= StWaitIdle;
            end
          end
        end
        StWaitIdle: begin
          if (sync2) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (runs at a scaled baud rate with exact DIV=8).
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CLK_HZ = 12000000;
  localparam int unsigned BAUD   = 93750;          // DIV = 8, 128 clocks per bit
  localparam realtime     CLK_P  = 83.334;
  localparam realtime     BIT_T  = 128 * CLK_P;

  logic       clk_12mhz = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx_pin = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor state, written only by the monitor process.
  logic [7:0] got_q[$];
  int fe_cnt = 0, ov_cnt = 0, vcyc = 0, err_long = 0;
  logic fe_prev = 1'b0, ov_prev = 1'b0;

  uart_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk_12mhz  (clk_12mhz),
    .rst        (rst),
    .uart_rx_pin(uart_rx_pin),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  always #(CLK_P / 2) clk_12mhz = ~clk_12mhz;

  always @(negedge clk_12mhz) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (rx_valid) vcyc++;
    if (frame_err) fe_cnt++;
    if (overrun_err) ov_cnt++;
    if ((frame_err && fe_prev) || (overrun_err && ov_prev)) err_long++;
    fe_prev = frame_err;
    ov_prev = overrun_err;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val, input logic par_flip);
    uart_rx_pin = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 8; i++) begin
      uart_rx_pin = b[i];
      #(BIT_T);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx_pin = (^b) ^ par_flip;
    #(BIT_T);
`else
    if (par_flip) uart_rx_pin = 1'b1;
`endif
    uart_rx_pin = stop_val;
    #(BIT_T);
    uart_rx_pin = 1'b1;
  endtask

  task automatic settle();
    repeat (8) @(negedge clk_12mhz);
  endtask

  int g0, fe0, ov0, v0;

  initial begin
    repeat (4) @(negedge clk_12mhz);
    check_eq("reset_rx_data", 32'(rx_data), 32'h00);
    check_eq("reset_rx_valid", 32'(rx_valid), 32'h0);
    check_eq("reset_frame_err", 32'(frame_err), 32'h0);
    check_eq("reset_overrun_err", 32'(overrun_err), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk_12mhz);

    // Single byte
    g0 = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt; v0 = vcyc;
    send_frame(8'h31, 1'b1, 1'b0);
    settle();
    check_eq("single_count", 32'(got_q.size() - g0), 32'd1);
    if (got_q.size() > g0) check_eq("single_byte", 32'(got_q[g0]), 32'h31);
    check_eq("single_valid_cycles", 32'(vcyc - v0), 32'd1);
    check_eq("single_no_fe", 32'(fe_cnt - fe0), 32'd0);
    check_eq("single_no_ov", 32'(ov_cnt - ov0), 32'd0);

    // Back-to-back stream
    g0 = got_q.size();
    send_frame(8'h31, 1'b1, 1'b0);
    send_frame(8'h32, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0);
    send_frame(8'h30, 1'b1, 1'b0);
    settle();
    check_eq("b2b_count", 32'(got_q.size() - g0), 32'd4);
    if (got_q.size() >= g0 + 4) begin
      check_eq("b2b_byte0", 32'(got_q[g0]), 32'h31);
      check_eq("b2b_byte1", 32'(got_q[g0+1]), 32'h32);
      check_eq("b2b_byte2", 32'(got_q[g0+2]), 32'h33);
      check_eq("b2b_byte3", 32'(got_q[g0+3]), 32'h30);
    end

    // Short glitch is a false start
    g0 = got_q.size(); fe0 = fe_cnt;
    @(posedge clk_12mhz); #1;
    uart_rx_pin = 1'b0;
    #2000;
    uart_rx_pin = 1'b1;
    #(2 * BIT_T);
    check_eq("glitch_no_valid", 32'(got_q.size() - g0), 32'd0);
    check_eq("glitch_no_fe", 32'(fe_cnt - fe0), 32'd0);
    check_eq("glitch_idle", 32'(dut.state), 32'(StIdle));

    // Bad stop bit, then recovery
    g0 = got_q.size(); fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    #(BIT_T);
    check_eq("badstop_fe", 32'(fe_cnt - fe0), 32'd1);
    check_eq("badstop_no_valid", 32'(got_q.size() - g0), 32'd0);
    send_frame(8'h31, 1'b1, 1'b0);
    settle();
    check_eq("badstop_recover_count", 32'(got_q.size() - g0), 32'd1);
    if (got_q.size() > g0) check_eq("badstop_recover_byte", 32'(got_q[g0]), 32'h31);

    // Overrun while consumer stalls
    @(posedge clk_12mhz); #1;
    rx_ready = 1'b0;
    g0 = got_q.size(); ov0 = ov_cnt;
    send_frame(8'h31, 1'b1, 1'b0);
    send_frame(8'h32, 1'b1, 1'b0);
    settle();
    check_eq("ovr_data_held", 32'(rx_data), 32'h31);
    check_eq("ovr_valid_held", 32'(rx_valid), 32'h1);
    check_eq("ovr_pulse", 32'(ov_cnt - ov0), 32'd1);
    @(posedge clk_12mhz); #1;
    rx_ready = 1'b1;
    @(negedge clk_12mhz);
    @(negedge clk_12mhz);
    check_eq("ovr_valid_cleared", 32'(rx_valid), 32'h0);
    check_eq("ovr_accept_count", 32'(got_q.size() - g0), 32'd1);
    if (got_q.size() > g0) check_eq("ovr_accept_byte", 32'(got_q[g0]), 32'h31);

    // Reset mid-byte, held through the rest of that frame
    g0 = got_q.size();
    fork
      send_frame(8'h31, 1'b1, 1'b0);
      begin
        #(5.5 * BIT_T);
        rst = 1'b1;
      end
    join
    @(negedge clk_12mhz);
    rst = 1'b0;
    settle();
    check_eq("rst_no_valid", 32'(rx_valid), 32'h0);
    check_eq("rst_data_cleared", 32'(rx_data), 32'h00);
    send_frame(8'h32, 1'b1, 1'b0);
    settle();
    check_eq("rst_count", 32'(got_q.size() - g0), 32'd1);
    if (got_q.size() > g0) check_eq("rst_byte", 32'(got_q[g0]), 32'h32);

`ifdef UART_RX_PARITY_EN
    g0 = got_q.size(); fe0 = fe_cnt;
    send_frame(8'h31, 1'b1, 1'b1);
    settle();
    check_eq("par_fe", 32'(fe_cnt - fe0), 32'd1);
    check_eq("par_no_valid", 32'(got_q.size() - g0), 32'd0);
`endif

    check_eq("err_pulse_width", 32'(err_long), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
